// File: rtl/id_pipe.sv
// id_pipe: RV32I decode stage with in-stage branch resolution, load-use interlock
// and wrong-path squash after a taken redirect.
module id_pipe #(
  parameter int XLEN      = 32,
  parameter int STALL_CYC = 1,
  parameter int SQUASH_N  = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     inst_i,
  input  logic [XLEN-1:0] pc_i,
  output logic [4:0]      rs1_addr_o,
  output logic [4:0]      rs2_addr_o,
  input  logic [XLEN-1:0] rs1_data_i,
  input  logic [XLEN-1:0] rs2_data_i,
  input  logic [4:0]      ex_rd_i,
  input  logic            ex_load_i,
  input  logic            flush_i,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_pc_plus4,
  output logic [XLEN-1:0] out_rs1,
  output logic [XLEN-1:0] out_rs2,
  output logic [XLEN-1:0] out_imm,
  output logic [4:0]      out_rd,
  output logic [2:0]      out_funct3,
  output logic            out_alu30,
  output logic            out_wb_en,
  output logic            out_load,
  output logic            out_store,
  output logic            out_csr,
  output logic            redir_o,
  output logic [XLEN-1:0] redir_pc_o
);
  typedef enum logic [1:0] {RUN, STALL, SQUASH} state_t;
  typedef struct packed {
    logic [XLEN-1:0] pc, pc4, rs1, rs2, imm;
    logic [4:0]      rd;
    logic [2:0]      f3;
    logic            a30, wb, ld, st, csr;
  } dec_t;
  state_t          state_q, state_d;
  logic [1:0]      cnt_q, cnt_d;
  dec_t            dec_q, dec_d;
  logic            valid_q, redir_q;
  logic [XLEN-1:0] redir_pc_q;
  logic [6:0]      op;
  logic [2:0]      f3;
  logic [4:0]      rd;
  logic is_lui, is_auipc, is_jal, is_jalr, is_br, is_ld, is_st, is_opi, is_op, is_sys;
  logic wb_op, uses1, uses2, hz, hz_run, adv, acc, keep, eq, lt, ltu, br_taken, taken;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm, sum_rs, sum_pc, target;
  assign op         = inst_i[6:0];
  assign f3         = inst_i[14:12];
  assign rd         = inst_i[11:7];
  assign rs1_addr_o = inst_i[19:15];
  assign rs2_addr_o = inst_i[24:20];
  assign is_lui   = op == 7'b0110111;
  assign is_auipc = op == 7'b0010111;
  assign is_jal   = op == 7'b1101111;
  assign is_jalr  = op == 7'b1100111;
  assign is_br    = op == 7'b1100011;
  assign is_ld    = op == 7'b0000011;
  assign is_st    = op == 7'b0100011;
  assign is_opi   = op == 7'b0010011;
  assign is_op    = op == 7'b0110011;
  assign is_sys   = op == 7'b1110011;
  assign imm_i = XLEN'($signed(inst_i[31:20]));
  assign imm_s = XLEN'($signed({inst_i[31:25], inst_i[11:7]}));
  assign imm_b = XLEN'($signed({inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0}));
  assign imm_u = XLEN'($signed({inst_i[31:12], 12'b0}));
  assign imm_j = XLEN'($signed({inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0}));
  assign imm = (is_lui || is_auipc) ? imm_u : is_jal ? imm_j : is_br ? imm_b : is_st ? imm_s :
               (is_jalr || is_ld || is_opi || is_sys) ? imm_i : '0;
  assign eq       = rs1_data_i == rs2_data_i;
  assign lt       = $signed(rs1_data_i) < $signed(rs2_data_i);
  assign ltu      = rs1_data_i < rs2_data_i;
  // funct3 bit 0 inverts the base compare; 010/011 are not branches
  assign br_taken = is_br && f3[2:1] != 2'b01 && ((f3[2] ? (f3[1] ? ltu : lt) : eq) ^ f3[0]);
  assign taken    = is_jal || is_jalr || br_taken;
  assign sum_rs   = rs1_data_i + imm;
  assign sum_pc   = pc_i + imm;
  assign target   = is_jalr ? {sum_rs[XLEN-1:1], 1'b0} : sum_pc;
  assign wb_op = is_lui || is_auipc || is_jal || is_jalr || is_ld || is_opi || is_op || is_sys;
  assign uses1 = is_jalr || is_br || is_ld || is_st || is_opi || is_op || (is_sys && !f3[2] && f3[1:0] != 2'b00);
  assign uses2 = is_br || is_st || is_op;
  assign hz     = ex_load_i && ex_rd_i != 5'd0 &&
                  ((uses1 && ex_rd_i == rs1_addr_o) || (uses2 && ex_rd_i == rs2_addr_o));
  assign hz_run   = hz && state_q == RUN;
  assign adv      = !valid_q || out_ready;
  assign in_ready = state_q != STALL && !hz_run && adv;
  assign acc      = in_valid && in_ready;
  assign keep     = acc && state_q == RUN && !flush_i;
  assign dec_d = '{pc: pc_i, pc4: pc_i + XLEN'(4), rs1: rs1_data_i, rs2: rs2_data_i, imm: imm,
                   rd: wb_op ? rd : 5'd0, f3: f3, a30: inst_i[30] && (is_op || (is_opi && f3 == 3'b101)),
                   wb: wb_op && rd != 5'd0, ld: is_ld, st: is_st, csr: is_sys};
  // the hazard-detect cycle itself is the first interlock cycle
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (flush_i) begin
      state_d = RUN;
      cnt_d   = '0;
    end else if (state_q == STALL) begin
      cnt_d   = cnt_q - 2'd1;
      state_d = cnt_q == 2'd1 ? RUN : STALL;
    end else if (state_q == SQUASH) begin
      cnt_d   = acc ? cnt_q - 2'd1 : cnt_q;
      state_d = acc && cnt_q == 2'd1 ? RUN : SQUASH;
    end else if (in_valid && hz) begin
      state_d = STALL_CYC > 1 ? STALL : RUN;
      cnt_d   = 2'(STALL_CYC - 1);
    end else if (keep && taken && SQUASH_N > 0) begin
      state_d = SQUASH;
      cnt_d   = 2'(SQUASH_N);
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RUN;
      cnt_q      <= '0;
      valid_q    <= 1'b0;
      dec_q      <= '0;
      redir_q    <= 1'b0;
      redir_pc_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      redir_q <= keep && taken;
      if (keep && taken) redir_pc_q <= target;
      if (flush_i) valid_q <= 1'b0;
      else if (adv) begin
        valid_q <= keep;
        dec_q   <= dec_d;
      end
    end
  end
  assign out_valid    = valid_q;
  assign out_pc       = dec_q.pc;
  assign out_pc_plus4 = dec_q.pc4;
  assign out_rs1      = dec_q.rs1;
  assign out_rs2      = dec_q.rs2;
  assign out_imm      = dec_q.imm;
  assign out_rd       = dec_q.rd;
  assign out_funct3   = dec_q.f3;
  assign out_alu30    = dec_q.a30;
  assign out_wb_en    = dec_q.wb;
  assign out_load     = dec_q.ld;
  assign out_store    = dec_q.st;
  assign out_csr      = dec_q.csr;
  assign redir_o      = redir_q;
  assign redir_pc_o   = redir_pc_q;
endmodule
